// File: rtl/isp_pkg.sv
// Shared ISP stream definitions: default pixel geometry and small index helpers
// used by the line buffer and the downstream window/kernel stages.
package isp_pkg;

  localparam int unsigned ISP_DATA_WIDTH = 8;
  localparam int unsigned ISP_IMG_WIDTH  = 1920;

  // Ceiling log2; clog2(1) is 0, callers guard single-entry cases themselves.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    while ((64'd1 << res) < 64'(value)) res = res + 1;
    return res;
  endfunction

  // LSB position of tap k inside a packed tap bus.
  function automatic int unsigned tapLsb(input int unsigned k, input int unsigned dataWidth);
    return k * dataWidth;
  endfunction

endpackage

// File: rtl/isp_line_buffer_if.sv
// Pixel-in / tap-column-out bus of the ISP line buffer.
interface isp_line_buffer_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LINES      = 3,
  parameter int unsigned ADDR_WIDTH = 11
);
  localparam int unsigned LINES_W = $clog2(LINES + 1);

  logic                          in_valid;
  logic                          in_sof;
  logic [DATA_WIDTH-1:0]         in_data;
  logic                          out_valid;
  logic [LINES*DATA_WIDTH-1:0]   out_taps;
  logic [ADDR_WIDTH-1:0]         out_col;
  logic                          out_eol;
  logic [LINES_W-1:0]            out_lines;

  modport master (
    output in_valid, in_sof, in_data,
    input  out_valid, out_taps, out_col, out_eol, out_lines
  );

  modport slave (
    input  in_valid, in_sof, in_data,
    output out_valid, out_taps, out_col, out_eol, out_lines
  );
endinterface

// File: rtl/lb_ram.sv
// Simple dual-port line RAM with registered read; read-first on address collision.
module lb_ram #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 1920,
  parameter int unsigned ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  wrEn,
  input  logic [ADDR_WIDTH-1:0] wrAddr,
  input  logic [DATA_WIDTH-1:0] wrData,
  input  logic                  rdEn,
  input  logic [ADDR_WIDTH-1:0] rdAddr,
  output logic [DATA_WIDTH-1:0] rdData
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Non-blocking read and write in one process give old data on collision.
  always_ff @(posedge clk) begin
    if (rdEn) rdData <= mem[rdAddr];
    if (wrEn) mem[wrAddr] <= wrData;
  end
endmodule

// File: rtl/isp_line_buffer.sv
// Multi-line buffer: one pixel in per valid cycle, a vertical column of LINES
// taps out one cycle later, with taps from lines not yet seen forced to zero.
module isp_line_buffer
  import isp_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = ISP_DATA_WIDTH,
  parameter int unsigned IMG_WIDTH  = ISP_IMG_WIDTH,
  parameter int unsigned LINES      = 3,
  parameter int unsigned ADDR_WIDTH = clog2(IMG_WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  isp_line_buffer_if.slave bus
);
  localparam int unsigned M       = LINES - 1;
  localparam int unsigned SEL_W   = (M > 1) ? clog2(M) : 1;
  localparam int unsigned CNT_W   = clog2(M + 1);
  localparam int unsigned LINES_W = clog2(LINES + 1);
  localparam int unsigned TAPS_W  = LINES * DATA_WIDTH;

  logic [ADDR_WIDTH-1:0] col, effCol, pipeCol;
  logic [SEL_W-1:0]      wrSel, effSel, pipeSel;
  logic [CNT_W-1:0]      lineCnt, effCnt, pipeCnt;
  logic                  lastCol;
  logic [M-1:0]          wrEn;
  logic [DATA_WIDTH-1:0] rdData [M];
  logic [DATA_WIDTH-1:0] pipeData, tapVal;
  logic                  validQ, eolQ;
  logic [LINES_W-1:0]    linesQ;
  logic [TAPS_W-1:0]     tapsC;
  int unsigned           ramIdx;

  // A start-of-frame pixel overrides the position state as column 0 of line 0.
  always_comb begin
    effCol  = bus.in_sof ? '0 : col;
    effSel  = bus.in_sof ? '0 : wrSel;
    effCnt  = bus.in_sof ? '0 : lineCnt;
    lastCol = (effCol == ADDR_WIDTH'(IMG_WIDTH - 1));
    wrEn    = '0;
    for (int unsigned j = 0; j < M; j++)
      wrEn[j] = bus.in_valid && (effSel == SEL_W'(j));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col     <= '0;
      wrSel   <= '0;
      lineCnt <= '0;
    end else if (bus.in_valid) begin
      if (lastCol) begin
        col     <= '0;
        wrSel   <= (effSel == SEL_W'(M - 1)) ? '0 : effSel + SEL_W'(1);
        lineCnt <= (effCnt == CNT_W'(M)) ? effCnt : effCnt + CNT_W'(1);
      end else begin
        col     <= effCol + ADDR_WIDTH'(1);
        wrSel   <= effSel;
        lineCnt <= effCnt;
      end
    end
  end

  for (genvar g = 0; g < M; g++) begin : gRam
    lb_ram #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (IMG_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH)
    ) uRam (
      .clk   (clk),
      .wrEn  (wrEn[g]),
      .wrAddr(effCol),
      .wrData(bus.in_data),
      .rdEn  (bus.in_valid),
      .rdAddr(effCol),
      .rdData(rdData[g])
    );
  end

  // Position state travels alongside the RAM read; everything holds on stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      validQ   <= 1'b0;
      pipeData <= '0;
      pipeCol  <= '0;
      pipeSel  <= '0;
      pipeCnt  <= '0;
      eolQ     <= 1'b0;
      linesQ   <= '0;
    end else begin
      validQ <= bus.in_valid;
      if (bus.in_valid) begin
        pipeData <= bus.in_data;
        pipeCol  <= effCol;
        pipeSel  <= effSel;
        pipeCnt  <= effCnt;
        eolQ     <= lastCol;
        linesQ   <= LINES_W'(effCnt) + LINES_W'(1);
      end
    end
  end

  // Tap k comes from the RAM k lines behind the one being written.
  always_comb begin
    tapsC  = '0;
    ramIdx = 0;
    tapVal = '0;
    tapsC[tapLsb(0, DATA_WIDTH) +: DATA_WIDTH] = pipeData;
    for (int unsigned k = 1; k <= M; k++) begin
      ramIdx = (32'(pipeSel) + M - k) % M;
      tapVal = '0;
      for (int unsigned j = 0; j < M; j++)
        if (j == ramIdx) tapVal = rdData[j];
      if (k <= 32'(pipeCnt)) tapsC[tapLsb(k, DATA_WIDTH) +: DATA_WIDTH] = tapVal;
    end
  end

  assign bus.out_valid = validQ;
  assign bus.out_taps  = tapsC;
  assign bus.out_col   = pipeCol;
  assign bus.out_eol   = eolQ;
  assign bus.out_lines = linesQ;
endmodule

// File: tb/tb_isp_line_buffer.sv
// Directed bench for isp_line_buffer: 3-tap/4-wide main instance plus
// 2-tap and 5-tap instances on a 5-wide line.
module tb_isp_line_buffer;
  import isp_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  isp_line_buffer_if #(.DATA_WIDTH(8), .LINES(3), .ADDR_WIDTH(2)) ifA ();
  isp_line_buffer_if #(.DATA_WIDTH(8), .LINES(2), .ADDR_WIDTH(3)) ifB ();
  isp_line_buffer_if #(.DATA_WIDTH(8), .LINES(5), .ADDR_WIDTH(3)) ifC ();

  isp_line_buffer #(.DATA_WIDTH(8), .IMG_WIDTH(4), .LINES(3), .ADDR_WIDTH(2))
    dutA (.clk(clk), .rst(rst), .bus(ifA.slave));
  isp_line_buffer #(.DATA_WIDTH(8), .IMG_WIDTH(5), .LINES(2), .ADDR_WIDTH(3))
    dutB (.clk(clk), .rst(rst), .bus(ifB.slave));
  isp_line_buffer #(.DATA_WIDTH(8), .IMG_WIDTH(5), .LINES(5), .ADDR_WIDTH(3))
    dutC (.clk(clk), .rst(rst), .bus(ifC.slave));

  // Expected {tap2,tap1,tap0} and out_lines for pixels 0x10..0x1F of a fresh frame.
  logic [23:0] expTaps [16] = '{
    24'h000010, 24'h000011, 24'h000012, 24'h000013,
    24'h001014, 24'h001115, 24'h001216, 24'h001317,
    24'h101418, 24'h111519, 24'h12161A, 24'h13171B,
    24'h14181C, 24'h15191D, 24'h161A1E, 24'h171B1F};
  logic [1:0] expLines [16] = '{
    2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pixA(input logic v, input logic sof, input logic [7:0] d);
    @(negedge clk);
    ifA.in_valid = v; ifA.in_sof = sof; ifA.in_data = d;
    @(posedge clk); #1;
  endtask

  task automatic pixBC(input logic v, input logic sof, input logic [7:0] d);
    @(negedge clk);
    ifB.in_valid = v; ifB.in_sof = sof; ifB.in_data = d;
    ifC.in_valid = v; ifC.in_sof = sof; ifC.in_data = d;
    @(posedge clk); #1;
  endtask

  task automatic chkA(input string tag, input int i);
    chk({tag, " valid"}, 64'(ifA.out_valid), 64'(1));
    chk({tag, " taps"},  64'(ifA.out_taps),  64'(expTaps[i]));
    chk({tag, " col"},   64'(ifA.out_col),   64'(i % 4));
    chk({tag, " eol"},   64'(ifA.out_eol),   64'((i % 4) == 3));
    chk({tag, " lines"}, 64'(ifA.out_lines), 64'(expLines[i]));
  endtask

  function automatic logic [7:0] pix(input int l, input int c);
    return 8'(l * 16 + c + 1);
  endfunction

  initial begin
    logic [15:0] expB;
    logic [39:0] expC;
    rst = 1'b1;
    ifA.in_valid = 1'b0; ifA.in_sof = 1'b0; ifA.in_data = '0;
    ifB.in_valid = 1'b0; ifB.in_sof = 1'b0; ifB.in_data = '0;
    ifC.in_valid = 1'b0; ifC.in_sof = 1'b0; ifC.in_data = '0;
    repeat (2) @(negedge clk);
    chk("reset valid", 64'(ifA.out_valid), 64'(0));
    chk("reset taps",  64'(ifA.out_taps),  64'(0));
    chk("reset col",   64'(ifA.out_col),   64'(0));
    chk("reset eol",   64'(ifA.out_eol),   64'(0));
    chk("reset lines", 64'(ifA.out_lines), 64'(0));
    chk("reset linesC", 64'(ifC.out_lines), 64'(0));
    rst = 1'b0;

    // Fill, rotation and saturated steady state over four lines.
    for (int i = 0; i < 16; i++) begin
      pixA(1'b1, i == 0, 8'(8'h10 + i));
      chkA($sformatf("fill px%0d", i), i);
    end
    pixA(1'b0, 1'b0, 8'h00);
    chk("idle valid", 64'(ifA.out_valid), 64'(0));
    chk("idle hold",  64'(ifA.out_taps),  64'(expTaps[15]));

    // Same frame again with 1- and 3-cycle gaps; stale RAM data must stay masked.
    for (int i = 0; i < 10; i++) begin
      pixA(1'b1, i == 0, 8'(8'h10 + i));
      chkA($sformatf("stall px%0d", i), i);
      if (i == 1 || i == 6) begin
        for (int g = 0; g < ((i == 1) ? 1 : 3); g++) begin
          pixA(1'b0, 1'b0, 8'hEE);
          chk($sformatf("gap%0d_%0d valid", i, g), 64'(ifA.out_valid), 64'(0));
          chk($sformatf("gap%0d_%0d taps", i, g), 64'(ifA.out_taps), 64'(expTaps[i]));
          chk($sformatf("gap%0d_%0d col", i, g), 64'(ifA.out_col), 64'(i % 4));
        end
      end
    end

    // Restart at column 2 of line 2.
    pixA(1'b1, 1'b1, 8'hA0);
    chk("sof taps",  64'(ifA.out_taps),  64'h0000A0);
    chk("sof col",   64'(ifA.out_col),   64'(0));
    chk("sof lines", 64'(ifA.out_lines), 64'(1));
    pixA(1'b1, 1'b0, 8'hA1);
    chk("sof+1 col",  64'(ifA.out_col),  64'(1));
    chk("sof+1 taps", 64'(ifA.out_taps), 64'h0000A1);
    pixA(1'b1, 1'b0, 8'hA2);
    pixA(1'b1, 1'b0, 8'hA3);
    chk("sof eol", 64'(ifA.out_eol), 64'(1));
    pixA(1'b1, 1'b0, 8'hB0);
    chk("line1 taps",  64'(ifA.out_taps),  64'h00A0B0);
    chk("line1 lines", 64'(ifA.out_lines), 64'(2));

    // Asynchronous reset between edges at column 1 of line 1.
    #2;
    rst = 1'b1; ifA.in_valid = 1'b0;
    #1;
    chk("arst valid", 64'(ifA.out_valid), 64'(0));
    chk("arst taps",  64'(ifA.out_taps),  64'(0));
    chk("arst lines", 64'(ifA.out_lines), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    pixA(1'b1, 1'b0, 8'hC5);
    chk("post-rst valid", 64'(ifA.out_valid), 64'(1));
    chk("post-rst col",   64'(ifA.out_col),   64'(0));
    chk("post-rst lines", 64'(ifA.out_lines), 64'(1));
    chk("post-rst taps",  64'(ifA.out_taps),  64'h0000C5);
    pixA(1'b0, 1'b0, 8'h00);

    // Sweep: LINES=2 and LINES=5 on a 5-pixel line, eight lines.
    for (int l = 0; l < 8; l++) begin
      for (int c = 0; c < 5; c++) begin
        pixBC(1'b1, (l == 0) && (c == 0), pix(l, c));
        expB = '0;
        for (int k = 0; k < 2; k++)
          if (k <= ((l < 1) ? l : 1)) expB[k*8 +: 8] = pix(l - k, c);
        expC = '0;
        for (int k = 0; k < 5; k++)
          if (k <= ((l < 4) ? l : 4)) expC[k*8 +: 8] = pix(l - k, c);
        chk($sformatf("B taps l%0d c%0d", l, c), 64'(ifB.out_taps), 64'(expB));
        chk($sformatf("C taps l%0d c%0d", l, c), 64'(ifC.out_taps), 64'(expC));
        chk($sformatf("B col l%0d c%0d", l, c), 64'(ifB.out_col), 64'(c));
        chk($sformatf("C eol l%0d c%0d", l, c), 64'(ifC.out_eol), 64'(c == 4));
        chk($sformatf("B lines l%0d c%0d", l, c), 64'(ifB.out_lines), 64'(((l < 1) ? l : 1) + 1));
        chk($sformatf("C lines l%0d c%0d", l, c), 64'(ifC.out_lines), 64'(((l < 4) ? l : 4) + 1));
      end
    end
    pixBC(1'b0, 1'b0, 8'h00);
    chk("C idle valid", 64'(ifC.out_valid), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
